clic_gateway: RTL and testbench

- Per-source interrupt gateway in front of the CLIC register adapter; its `ip_o` drives the adapter's `ip_i` directly.
- Synchronises raw interrupt lines and applies level or edge semantics per source. Edge sources get a pending bit that holds until it is cleared.
- Pending bits are cleared by the core's claim handshake or by software pulses derived from register writes.

---
 rtl/clic_reg_pkg.sv | 17 +
 rtl/clic_gw_channel.sv | 74 +++++++
 rtl/clic_gateway.sv | 68 ++++++
 tb/tb_clic_gateway.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clic_reg_pkg.sv
// Shared CLIC register constants: source count and trigger-attribute encodings.
// Imported by the interrupt gateway and its per-source channel.
package clic_reg_pkg;

    localparam int NumSrc = 32;

    // attr_trig[0] selects level/edge, attr_trig[1] selects polarity
    localparam logic TRIG_LEVEL = 1'b0;
    localparam logic TRIG_EDGE  = 1'b1;
    localparam logic TRIG_POS   = 1'b0;
    localparam logic TRIG_NEG   = 1'b1;

    function automatic logic claim_hit(input logic valid, input int id, input int idx);
        return valid && (id == idx);
    endfunction

endpackage

// File: rtl/clic_gw_channel.sv
// Single-source gateway slice: synchroniser, edge history, pending flop and output select.
// Polarity inversion is applied before the synchroniser so it travels with the data.
module clic_gw_channel
    import clic_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_src,
    input  logic i_pol,
    input  logic i_le,
    input  logic i_sw_set,
    input  logic i_sw_clr,
    input  logic i_claim,
    output logic o_ip
);

    logic w_raw;
    logic w_s;
    logic w_rise;
    logic w_set;
    logic w_clr;
    logic w_edge_mode;
    logic r_hist;
    logic r_pend;

    assign w_raw = i_src ^ (i_pol == TRIG_NEG);

    if (SYNC_STAGES == 0) begin : g_nosync
        assign w_s = w_raw;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] r_sync;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_sync <= '0;
            end else begin
                r_sync[0] <= w_raw;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    r_sync[k] <= r_sync[k-1];
                end
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];
    end

    assign w_edge_mode = (i_le == TRIG_EDGE);
    assign w_rise      = w_s & ~r_hist;
    assign w_set       = w_rise | i_sw_set;
    assign w_clr       = i_sw_clr | i_claim;

    // History tracks s in every mode so switching to edge never fabricates an edge;
    // set has priority so an edge landing on its own claim is kept.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_hist <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_hist <= w_s;
            if (!w_edge_mode) begin
                r_pend <= 1'b0;
            end else if (w_set) begin
                r_pend <= 1'b1;
            end else if (w_clr) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_ip = rst_ni & (w_edge_mode ? r_pend : w_s);

endmodule

// File: rtl/clic_gateway.sv
// Per-source interrupt gateway feeding the CLIC register adapter's ip_i.
// Define CLIC_GW_POLARITY_EN to add the pol_i port for active-low / falling-edge sources.
module clic_gateway
    import clic_reg_pkg::*;
#(
    parameter int N_SOURCE    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int SRC_W       = $clog2(N_SOURCE)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SOURCE-1:0] intr_src_i,
`ifdef CLIC_GW_POLARITY_EN
    input  logic [N_SOURCE-1:0] pol_i,
`endif
    input  logic [N_SOURCE-1:0] le_i,
    input  logic [N_SOURCE-1:0] sw_set_i,
    input  logic [N_SOURCE-1:0] sw_clr_i,
    input  logic                claim_valid_i,
    input  logic [SRC_W-1:0]    claim_id_i,
    output logic                claim_ready_o,
    output logic [N_SOURCE-1:0] ip_o
);

    if (N_SOURCE != NumSrc) begin : g_bad_nsrc
        $fatal(1, "clic_gateway: N_SOURCE must equal clic_reg_pkg::NumSrc");
    end

    logic [N_SOURCE-1:0] w_pol;
    logic [N_SOURCE-1:0] w_claim_hit;
    logic                r_claim_ready;

`ifdef CLIC_GW_POLARITY_EN
    assign w_pol = pol_i;
`else
    assign w_pol = '0;
`endif

    // Out-of-range IDs simply match no channel; the claim is still acknowledged.
    for (genvar i = 0; i < N_SOURCE; i++) begin : g_ch
        assign w_claim_hit[i] = claim_hit(claim_valid_i, int'(claim_id_i), i);

        clic_gw_channel #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_channel (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .i_src    (intr_src_i[i]),
            .i_pol    (w_pol[i]),
            .i_le     (le_i[i]),
            .i_sw_set (sw_set_i[i]),
            .i_sw_clr (sw_clr_i[i]),
            .i_claim  (w_claim_hit[i]),
            .o_ip     (ip_o[i])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_claim_ready <= 1'b0;
        end else begin
            r_claim_ready <= claim_valid_i;
        end
    end

    assign claim_ready_o = r_claim_ready;

endmodule

// File: tb/tb_clic_gateway.sv
// Directed self-checking bench for clic_gateway (SYNC_STAGES=2, N_SOURCE=32, 6-bit claim ID).
// Polarity scenario compiles in only when CLIC_GW_POLARITY_EN is defined.
module tb_clic_gateway;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] intr_src_i;
    logic [31:0] pol_i;
    logic [31:0] le_i;
    logic [31:0] sw_set_i;
    logic [31:0] sw_clr_i;
    logic        claim_valid_i;
    logic [5:0]  claim_id_i;
    logic        claim_ready_o;
    logic [31:0] ip_o;

    int          nTests = 0;
    int          nFails = 0;
    logic [32:0] expVal;

    clic_gateway #(
        .N_SOURCE    (32),
        .SYNC_STAGES (2),
        .SRC_W       (6)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .intr_src_i    (intr_src_i),
`ifdef CLIC_GW_POLARITY_EN
        .pol_i         (pol_i),
`endif
        .le_i          (le_i),
        .sw_set_i      (sw_set_i),
        .sw_clr_i      (sw_clr_i),
        .claim_valid_i (claim_valid_i),
        .claim_id_i    (claim_id_i),
        .claim_ready_o (claim_ready_o),
        .ip_o          (ip_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance n edges, landing 1 time unit after the last one (drive/sample point).
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; intr_src_i = 32'h4; pol_i = '0; le_i = ~32'h20;
        sw_set_i = '0; sw_clr_i = '0; claim_valid_i = 1'b0; claim_id_i = '0;
        step(3);
        expVal = {1'b0, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL reset_hold: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        rst_ni = 1'b1;
        step(2);
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL reset_cycle2: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        step(1);
        expVal = {1'b0, 32'h4};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL reset_cycle3: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        sw_clr_i = 32'h4;
        step(1);
        sw_clr_i = '0;
        step(4);
        expVal = {1'b0, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL reset_single_edge: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        intr_src_i = '0;
        step(3);
    endtask

    task automatic test_edge_capture();
        intr_src_i[3] = 1'b1;
        step(1);
        intr_src_i[3] = 1'b0;
        step(1);
        expVal = {1'b0, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL edge_t2: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        step(1);
        expVal = {1'b0, 32'h8};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL edge_t3: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        step(5);
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL edge_hold: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        claim_valid_i = 1'b1; claim_id_i = 6'd3;
        step(1);
        claim_valid_i = 1'b0;
        expVal = {1'b1, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL edge_claim: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        step(1);
        expVal = {1'b0, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL ready_single: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
    endtask

    task automatic test_level_follow();
        intr_src_i[5] = 1'b1;
        step(1);
        expVal = {1'b0, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL level_t1: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        step(1);
        expVal = {1'b0, 32'h20};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL level_t2: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        sw_clr_i[5] = 1'b1; claim_valid_i = 1'b1; claim_id_i = 6'd5;
        step(1);
        sw_clr_i = '0; claim_valid_i = 1'b0;
        expVal = {1'b1, 32'h20};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL level_ignore_clr: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        intr_src_i[5] = 1'b0;
        step(2);
        expVal = {1'b0, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL level_fall: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
    endtask

    task automatic test_simultaneous();
        sw_set_i[7] = 1'b1;
        step(1);
        sw_set_i = '0;
        intr_src_i[7] = 1'b1;
        step(2);
        claim_valid_i = 1'b1; claim_id_i = 6'd7;
        step(1);
        expVal = {1'b1, 32'h80};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL edge_beats_claim: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        step(1);
        claim_valid_i = 1'b0;
        expVal = {1'b1, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL claim_alone: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        sw_set_i[7] = 1'b1; sw_clr_i[7] = 1'b1;
        step(1);
        sw_set_i = '0; sw_clr_i = '0;
        expVal = {1'b0, 32'h80};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL set_beats_clr: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        sw_clr_i[7] = 1'b1; intr_src_i[7] = 1'b0;
        step(1);
        sw_clr_i = '0;
        step(3);
    endtask

    task automatic test_sw_pulses();
        sw_set_i[0] = 1'b1;
        step(1);
        sw_set_i = '0;
        expVal = {1'b0, 32'h1};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL sw_set: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        claim_valid_i = 1'b1; claim_id_i = 6'd40;
        step(1);
        claim_valid_i = 1'b0;
        expVal = {1'b1, 32'h1};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL claim_out_of_range: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        sw_clr_i[0] = 1'b1;
        step(1);
        sw_clr_i = '0;
        expVal = {1'b0, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL sw_clr: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
    endtask

    task automatic test_back_to_back();
        sw_set_i = 32'h300;
        step(1);
        sw_set_i = '0;
        claim_valid_i = 1'b1; claim_id_i = 6'd8;
        step(1);
        claim_id_i = 6'd9;
        expVal = {1'b1, 32'h200};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL b2b_first: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        step(1);
        claim_valid_i = 1'b0;
        expVal = {1'b1, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL b2b_second: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        step(1);
    endtask

    task automatic test_mode_switch();
        sw_set_i[10] = 1'b1;
        step(1);
        sw_set_i = '0;
        le_i[10] = 1'b0;
        step(1);
        le_i[10] = 1'b1;
        #1;
        expVal = {1'b0, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL mode_discard: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        le_i[11] = 1'b0; intr_src_i[11] = 1'b1;
        step(3);
        expVal = {1'b0, 32'h800};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL mode_level_high: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        le_i[11] = 1'b1;
        step(3);
        expVal = {1'b0, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL mode_no_spurious: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        intr_src_i[11] = 1'b0;
        step(3);
    endtask

    task automatic test_reset_mid();
        sw_set_i = 32'hF000;
        step(1);
        sw_set_i = '0;
        expVal = {1'b0, 32'hF000};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL mid_pending: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        rst_ni = 1'b0;
        step(1);
        rst_ni = 1'b1;
        expVal = {1'b0, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL mid_reset: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        step(4);
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL mid_lost: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
    endtask

`ifdef CLIC_GW_POLARITY_EN
    task automatic test_polarity();
        intr_src_i[1] = 1'b1; pol_i[1] = 1'b1;
        step(4);
        expVal = {1'b0, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL pol_idle: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        intr_src_i[1] = 1'b0;
        step(2);
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL pol_t2: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        step(1);
        expVal = {1'b0, 32'h2};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL pol_fall: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
        claim_valid_i = 1'b1; claim_id_i = 6'd1;
        step(1);
        claim_valid_i = 1'b0;
        intr_src_i[1] = 1'b1;
        step(4);
        expVal = {1'b0, 32'h0};
        nTests++; if ({claim_ready_o, ip_o} !== expVal) begin nFails++; $display("[TB] FAIL pol_rise_ignored: got %h expected %h", {claim_ready_o, ip_o}, expVal); end
    endtask
`endif

    initial begin
        test_reset();
        test_edge_capture();
        test_level_follow();
        test_simultaneous();
        test_sw_pulses();
        test_back_to_back();
        test_mode_switch();
        test_reset_mid();
`ifdef CLIC_GW_POLARITY_EN
        test_polarity();
`endif
        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
